// File: rtl/gb_reg_file.sv
// Register file and writeback stage for the 8-bit ALU: combinational operand/flag
// reads, byte writeback with masked flag update, and 16-bit pair load/inc/dec.
module gb_reg_file #(
  parameter bit POSTBOOT_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  rdSelA,
  input  logic [2:0]  rdSelB,
  input  logic [7:0]  memIn,
  output logic [7:0]  rdDataA,
  output logic [7:0]  rdDataB,
  output logic [7:0]  flagsOut,
  input  logic        wbEn,
  input  logic [2:0]  wbSel,
  input  logic [7:0]  wbData,
  input  logic [3:0]  flagMask,
  input  logic [7:0]  flagsNew,
  input  logic [1:0]  pairSel,
  input  logic [1:0]  pairOp,
  input  logic [15:0] pairData,
  output logic [15:0] pairRd,
  output logic [15:0] hlOut
);
  // Slots follow the operand select encoding. Slot 6 is never a byte target
  // ((HL) goes to memory), so it holds F.
  localparam logic [2:0] IDX_F = 3'd6;
  localparam logic [1:0] OP_LD = 2'd1, OP_INC = 2'd2, OP_DEC = 2'd3;
  localparam logic [1:0] P_AF  = 2'd3;

  localparam logic [7:0][7:0] RST_VAL = POSTBOOT_INIT ?
    {8'h01, 8'hB0, 8'h4D, 8'h01, 8'hD8, 8'h00, 8'h13, 8'h00} : 64'h0;

  logic [7:0][7:0] r_q, r_d;
  logic [2:0]      hi_idx, lo_idx;
  logic [15:0]     pair_cur;
  logic [7:0]      f_base;

  always_comb begin
    hi_idx = 3'd0;
    lo_idx = 3'd1;
    case (pairSel)
      2'd0:    begin hi_idx = 3'd0; lo_idx = 3'd1;  end
      2'd1:    begin hi_idx = 3'd2; lo_idx = 3'd3;  end
      2'd2:    begin hi_idx = 3'd4; lo_idx = 3'd5;  end
      default: begin hi_idx = 3'd7; lo_idx = IDX_F; end
    endcase
  end

  assign pair_cur = {r_q[hi_idx], r_q[lo_idx]};
  assign pairRd   = pair_cur;
  assign hlOut    = {r_q[4], r_q[5]};
  assign flagsOut = r_q[IDX_F];
  assign rdDataA  = (rdSelA == 3'd6) ? memIn : r_q[rdSelA];
  assign rdDataB  = (rdSelB == 3'd6) ? memIn : r_q[rdSelB];

  always_comb begin
    r_d    = r_q;
    f_base = r_q[IDX_F];
    if (wbEn && wbSel != 3'd6)
      r_d[wbSel] = wbData;
    // Pair ops are applied after the byte write so they win on a shared half.
    case (pairOp)
      OP_LD: begin
        r_d[hi_idx] = pairData[15:8];
        if (pairSel == P_AF) f_base = pairData[7:0];
        else                 r_d[lo_idx] = pairData[7:0];
      end
      OP_INC, OP_DEC: begin
        if (pairSel != P_AF)
          {r_d[hi_idx], r_d[lo_idx]} = (pairOp == OP_INC) ? pair_cur + 16'd1
                                                          : pair_cur - 16'd1;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      r_d[IDX_F][4+i] = flagMask[i] ? flagsNew[4+i] : f_base[4+i];
    r_d[IDX_F][3:0] = 4'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RST_VAL;
    else        r_q <= r_d;
  end
endmodule

// File: doc/gb_reg_file.md
Name: gb_reg_file

Overview:
- CPU register file and writeback stage for the 8-bit ALU.
- Supplies both ALU operands and the current flag byte (flagsIn) combinationally from registers A,F,B,C,D,E,H,L.
- On the next clock edge, captures the ALU result and flagsOut under per-flag update masks.
- Also provides 16-bit register-pair read, load, increment and decrement for BC/DE/HL/AF (INC rr, DEC rr, LD rr, HL+/HL- addressing).

Parameters:
- POSTBOOT_INIT, 1: 1 gives DMG post-boot reset values (A=01 F=B0 B=00 C=13 D=00 E=D8 H=01 L=4D); 0 resets all registers to 00.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdSelA  in  3  operand A select: 0=B 1=C 2=D 3=E 4=H 5=L 6=(HL) 7=A
- rdSelB  in  3  operand B select, same encoding
- memIn  in  8  memory byte returned for select 6 ((HL))
- rdDataA  out  8  operand A to ALU regA
- rdDataB  out  8  operand B to ALU regB
- flagsOut  out  8  current F register to ALU flagsIn
- wbEn  in  1  byte writeback strobe
- wbSel  in  3  writeback target, same encoding
- wbData  in  8  ALU res
- flagMask  in  4  per-flag update enables {Z,N,H,C}
- flagsNew  in  8  ALU flagsOut
- pairSel  in  2  0=BC 1=DE 2=HL 3=AF
- pairOp  in  2  0=none 1=load pairData 2=increment 3=decrement
- pairData  in  16  load value
- pairRd  out  16  selected pair, combinational
- hlOut  out  16  current HL, for the address bus

Behaviour:
- Reset (async, rst_n low): all registers take POSTBOOT_INIT values immediately. Outputs follow combinationally from those values.
- Reads are purely combinational from register state.
  - Select 6 returns memIn.
  - There is no write-to-read bypass; a write becomes visible the cycle after the edge.
- Byte writeback: on a rising edge with wbEn=1, register[wbSel] <= wbData. wbSel=6 is ignored, because (HL) stores go through the memory path.
- Flag update: on every rising edge, F[7:4] bit i <= flagsNew bit i where flagMask bit i=1, otherwise F holds.
  - F[3:0] is always 0: forced on every write path, including reset and AF load.
  - flagMask=0000 is used for CP-free ops like LD, RES and SET.
  - flagMask=1110 is used for INC and DEC (C preserved).
- Pair ops, applied on the rising edge to pairSel:
  - load: hi <= pairData[15:8], lo <= pairData[7:0]; for AF, F <= {pairData[7:4],4'b0}.
  - inc/dec: 16-bit modulo arithmetic. FFFF+1=0000 and 0000-1=FFFF; the carry/borrow is discarded and flags are not touched.
  - inc/dec of AF is illegal and is ignored (no change).
- Simultaneous events:
  - A byte writeback and a pair op targeting different registers both take effect, e.g. LD A,(HL+): wbSel=7 plus pairOp=2 on HL.
  - If they target the same 8-bit register, the pair op wins and the byte write to that half is dropped.
  - A pair load of AF with a nonzero flagMask in the same cycle: masked flag bits take flagsNew; unmasked F bits take pairData.
- Reset asserted mid-cycle overrides everything asynchronously. Deassertion is synchronised externally.

Test Plan:
1. Reset with POSTBOOT_INIT=1, then rdSelA=7, rdSelB=1 -> rdDataA=01, rdDataB=13, flagsOut=B0, hlOut=014D.
2. wbEn=1, wbSel=2, wbData=5A, flagMask=1111, flagsNew=FF -> next cycle D=5A, flagsOut=F0 (low nibble forced 0).
3. flagMask=1110, flagsNew=00 with F=B0 -> F=10 (C kept); wbSel=6 with wbData=77 -> no register changes.
4. pairSel=2, pairOp=1, pairData=FFFF, then pairOp=2 -> HL=0000, F unchanged; then pairOp=3 -> HL=FFFF.
5. Same cycle: wbEn=1, wbSel=7, wbData=3C and pairSel=2, pairOp=2 from HL=C000 -> A=3C, HL=C001. Same cycle: wbSel=4, wbData=99 with pairOp=1 HL<=1234 -> HL=1234.
6. Pair load AF with pairData=12FF -> A=12, F=F0. Assert rst_n=0 asynchronously mid-cycle -> all registers immediately return to POSTBOOT_INIT values.
